// File: rtl/config_chain_sequencer_if.sv
// Word stream between the bitstream buffer and the config chain sequencer.
// The buffer drives the word and its valid flag, and the sequencer drives ready.
interface config_chain_sequencer_if #(
    parameter int LANE_W = 8
);
    logic                  word_valid_i;
    logic [4*LANE_W-1:0]   word_data_i;
    logic                  word_ready_o;

    modport master (output word_valid_i, word_data_i, input word_ready_o);
    modport slave  (input word_valid_i, word_data_i, output word_ready_o);
endinterface

// File: rtl/config_chain_sequencer.sv
// Serialises 32-bit bitstream words onto four config chains, one byte lane per chain, LSB first.
// After the last word it issues a single set strobe that latches every chain.
module config_chain_sequencer #(
    parameter int LEN_W  = 16,
    parameter int LANE_W = 8
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    input  logic                   start_i,
    input  logic [LEN_W-1:0]       len_i,
    input  logic                   abort_i,
    config_chain_sequencer_if.slave word_if,
    output logic                   cen,
    output logic [3:0]             shift_out,
    output logic [3:0]             set_out,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   aborted_o,
    output logic [LEN_W-1:0]       words_left_o
);
    localparam int NUM_LANES = 4;
    localparam int IDX_W     = (LANE_W > 1) ? $clog2(LANE_W) : 1;

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_SHIFT, S_SET, S_FIN} state_t;

    state_t                              state;
    logic [IDX_W-1:0]                    bit_idx;
    logic [NUM_LANES-1:0][LANE_W-1:0]    word_lanes, sh_reg, sh_load, sh_next;
    logic [NUM_LANES-1:0]                word_lsb, sh_lsb;

    assign word_lanes = word_if.word_data_i;

    // sh_reg holds the bits not yet presented; shift_out is the registered current bit.
    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        assign word_lsb[k] = word_lanes[k][0];
        assign sh_lsb[k]   = sh_reg[k][0];
        assign sh_load[k]  = word_lanes[k] >> 1;
        assign sh_next[k]  = sh_reg[k] >> 1;
    end

    // An abort in the same cycle must not let the buffer pop a word.
    assign word_if.word_ready_o = (state == S_WAIT) && !abort_i && !wb_rst_i;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state        <= S_IDLE;
            bit_idx      <= '0;
            sh_reg       <= '0;
            cen          <= 1'b0;
            shift_out    <= '0;
            set_out      <= '0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            aborted_o    <= 1'b0;
            words_left_o <= '0;
        end else begin
            done_o    <= 1'b0;
            aborted_o <= 1'b0;
            set_out   <= '0;
            if (abort_i && state != S_IDLE) begin
                state     <= S_IDLE;
                busy_o    <= 1'b0;
                cen       <= 1'b0;
                shift_out <= '0;
                aborted_o <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start_i && !abort_i) begin
                            busy_o <= 1'b1;
                            if (len_i != '0) begin
                                words_left_o <= len_i;
                                state        <= S_WAIT;
                            end else begin
                                done_o <= 1'b1;
                                state  <= S_FIN;
                            end
                        end
                    end
                    S_WAIT: begin
                        if (word_if.word_valid_i) begin
                            sh_reg    <= sh_load;
                            shift_out <= word_lsb;
                            cen       <= 1'b1;
                            bit_idx   <= '0;
                            state     <= S_SHIFT;
                        end
                    end
                    S_SHIFT: begin
                        if (bit_idx == IDX_W'(LANE_W - 1)) begin
                            words_left_o <= words_left_o - 1'b1;
                            cen          <= 1'b0;
                            shift_out    <= '0;
                            if (words_left_o == LEN_W'(1)) begin
                                set_out <= 4'hF;
                                done_o  <= 1'b1;
                                state   <= S_SET;
                            end else begin
                                state <= S_WAIT;
                            end
                        end else begin
                            bit_idx   <= bit_idx + 1'b1;
                            shift_out <= sh_lsb;
                            sh_reg    <= sh_next;
                        end
                    end
                    S_SET, S_FIN: begin
                        busy_o <= 1'b0;
                        state  <= S_IDLE;
                    end
                    default: begin
                        busy_o <= 1'b0;
                        state  <= S_IDLE;
                    end
                endcase
            end
        end
    end
endmodule
